// File: rtl/floating_point_div_seq_if.sv
// Operand/result handshake bus shared by the sequential FP divider and its driver.
// Defining FP_DIV_FLAGS_EN adds the IEEE exception flags that travel with the result.
interface floating_point_div_seq_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
`ifdef FP_DIV_FLAGS_EN
    logic         div_by_zero;
    logic         invalid;
    logic         underflow;
    logic         inexact;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, overflow,
        input  div_by_zero, invalid, underflow, inexact
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, overflow,
        output div_by_zero, invalid, underflow, inexact
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, overflow
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, overflow
    );
`endif
endinterface

// File: rtl/floating_point_div_seq.sv
// Sequential IEEE-754 single-precision divider (a / b), radix-2 restoring, one quotient bit per clock.
// Optional FP_DIV_FLAGS_EN adds div_by_zero/invalid/underflow/inexact outputs on the bus.
module floating_point_div_seq #(
    parameter int W     = 32,
    parameter int QBITS = 27
) (
    input  logic                     clk,
    input  logic                     rst_n,
    floating_point_div_seq_if.slave  bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_NORM = 3'd3;
    localparam logic [2:0] S_RND  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [2:0] K_NONE = 3'd0;
    localparam logic [2:0] K_NAN  = 3'd1;
    localparam logic [2:0] K_DBZ  = 3'd2;
    localparam logic [2:0] K_INF  = 3'd3;
    localparam logic [2:0] K_ZERO = 3'd4;

    localparam logic [4:0]   LAST_CNT = 5'(QBITS - 1);
    localparam logic [W-1:0] QNAN     = 32'h7FC0_0000;

    logic [2:0]         r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic [23:0]        r_mb;
    logic [24:0]        r_rem;
    logic [QBITS-1:0]   r_q;
    logic [4:0]         r_cnt;
    logic               r_sticky;
    logic               r_special;
    logic [W-1:0]       r_result;
    logic               r_overflow;
`ifdef FP_DIV_FLAGS_EN
    logic               r_div_by_zero;
    logic               r_invalid;
    logic               r_underflow;
    logic               r_inexact;
`endif

    // Operand unpack; exponent field 0 is treated as zero (denormals flushed).
    logic [7:0]         w_ea;
    logic [7:0]         w_eb;
    logic [22:0]        w_fa;
    logic [22:0]        w_fb;
    logic               w_a_zero, w_a_inf, w_a_nan;
    logic               w_b_zero, w_b_inf, w_b_nan;
    logic               w_sign;
    logic signed [9:0]  w_exp_pre;
    logic [2:0]         w_kind;
    logic [W-1:0]       w_spec_res;

    assign w_ea     = r_a[30:23];
    assign w_eb     = r_b[30:23];
    assign w_fa     = r_a[22:0];
    assign w_fb     = r_b[22:0];
    assign w_sign   = r_a[31] ^ r_b[31];
    assign w_a_zero = (w_ea == 8'h00);
    assign w_b_zero = (w_eb == 8'h00);
    assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
    assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
    assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
    assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);

    assign w_exp_pre = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_kind = K_NONE;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))
            w_kind = K_NAN;
        else if (w_b_zero)
            w_kind = w_a_inf ? K_INF : K_DBZ;
        else if (w_a_inf)
            w_kind = K_INF;
        else if (w_a_zero || w_b_inf)
            w_kind = K_ZERO;
    end

    always_comb begin
        w_spec_res = {w_sign, 31'd0};
        case (w_kind)
            K_NAN:        w_spec_res = QNAN;
            K_DBZ, K_INF: w_spec_res = {w_sign, 8'hFF, 23'd0};
            default:      w_spec_res = {w_sign, 31'd0};
        endcase
    end

    // Restoring step: try rem - divisor; keep the difference only when it stays non-negative.
    logic [25:0] w_diff;
    logic        w_ge;
    logic [24:0] w_rem_kept;

    assign w_diff     = {1'b0, r_rem} - {2'b00, r_mb};
    assign w_ge       = ~w_diff[25];
    assign w_rem_kept = w_ge ? w_diff[24:0] : r_rem;

    // Rounding: q is normalised with the integer bit at the top, then 23 mantissa bits, guard, round.
    logic [22:0]        w_mant;
    logic               w_g, w_r, w_s;
    logic               w_rup;
    logic [23:0]        w_mant_sum;
    logic signed [9:0]  w_exp_rnd;
    logic               w_ovf;
    logic               w_unf;

    assign w_mant     = r_q[QBITS-2:3];
    assign w_g        = r_q[2];
    assign w_r        = r_q[1];
    assign w_s        = r_q[0] | r_sticky;
    assign w_rup      = w_g & (w_r | w_s | w_mant[0]);
    assign w_mant_sum = {1'b0, w_mant} + {23'd0, w_rup};
    assign w_exp_rnd  = r_exp + (w_mant_sum[23] ? 10'sd1 : 10'sd0);
    assign w_ovf      = (w_exp_rnd >= 10'sd255);
    assign w_unf      = (w_exp_rnd <= 10'sd0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_mb       <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_sticky   <= 1'b0;
            r_special  <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
`ifdef FP_DIV_FLAGS_EN
            r_div_by_zero <= 1'b0;
            r_invalid     <= 1'b0;
            r_underflow   <= 1'b0;
            r_inexact     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_state <= S_PREP;
`ifdef FP_DIV_FLAGS_EN
                        r_div_by_zero <= 1'b0;
                        r_invalid     <= 1'b0;
                        r_underflow   <= 1'b0;
                        r_inexact     <= 1'b0;
`endif
                    end
                end
                S_PREP: begin
                    r_sign    <= w_sign;
                    r_exp     <= w_exp_pre;
                    r_rem     <= {2'b01, w_fa};
                    r_mb      <= {1'b1, w_fb};
                    r_q       <= '0;
                    r_cnt     <= '0;
                    r_sticky  <= 1'b0;
                    r_special <= (w_kind != K_NONE);
                    if (w_kind != K_NONE) begin
                        // Specials finish through RND so both paths share the DONE entry.
                        r_result   <= w_spec_res;
                        r_overflow <= 1'b0;
                        r_state    <= S_RND;
`ifdef FP_DIV_FLAGS_EN
                        r_invalid     <= (w_kind == K_NAN);
                        r_div_by_zero <= (w_kind == K_DBZ);
`endif
                    end else begin
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_q   <= {r_q[QBITS-2:0], w_ge};
                    r_rem <= w_rem_kept << 1;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == LAST_CNT)
                        r_state <= S_NORM;
                end
                S_NORM: begin
                    if (!r_q[QBITS-1]) begin
                        r_q   <= r_q << 1;
                        r_exp <= r_exp - 10'sd1;
                    end
                    r_sticky <= |r_rem;
                    r_state  <= S_RND;
                end
                S_RND: begin
                    if (!r_special) begin
                        r_overflow <= w_ovf;
                        if (w_ovf)
                            r_result <= {r_sign, 8'hFF, 23'd0};
                        else if (w_unf)
                            r_result <= {r_sign, 31'd0};
                        else
                            r_result <= {r_sign, w_exp_rnd[7:0], w_mant_sum[22:0]};
`ifdef FP_DIV_FLAGS_EN
                        r_underflow <= w_unf;
                        r_inexact   <= w_g | w_r | w_s | w_ovf | w_unf;
`endif
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.overflow  = r_overflow;
`ifdef FP_DIV_FLAGS_EN
    assign bus.div_by_zero = r_div_by_zero;
    assign bus.invalid     = r_invalid;
    assign bus.underflow   = r_underflow;
    assign bus.inexact     = r_inexact;
`endif

endmodule

// File: tb/tb_floating_point_div_seq.sv
// Directed self-checking bench for floating_point_div_seq: values, latency, specials, backpressure, reset abort.
`timescale 1ns/1ps
module tb_floating_point_div_seq;
    logic clk = 1'b0;
    logic rst_n;

    floating_point_div_seq_if intf();

    floating_point_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one operation from IDLE (called #1 after an edge), optionally hold off out_ready for
    // `hold` cycles while poking in_valid, then retire it.
    // exp_flags = {div_by_zero, invalid, underflow, inexact}.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_ovf, input int exp_lat,
                         input logic [3:0] exp_flags, input int hold);
        int lat;
        intf.a        = a;
        intf.b        = b;
        intf.in_valid = 1'b1;
        @(posedge clk); #1;
        intf.in_valid = 1'b0;
        intf.a        = 32'hDEAD_BEEF;
        intf.b        = 32'h1234_5678;
        check({tag, ".in_ready_low"}, {31'd0, intf.in_ready}, 32'd0);
        lat = 0;
        while (!intf.out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".result"}, intf.result, exp_res);
        check({tag, ".overflow"}, {31'd0, intf.overflow}, {31'd0, exp_ovf});
`ifdef FP_DIV_FLAGS_EN
        check({tag, ".flags"},
              {28'd0, intf.div_by_zero, intf.invalid, intf.underflow, intf.inexact},
              {28'd0, exp_flags});
`endif
        for (int i = 0; i < hold; i++) begin
            intf.in_valid = (i % 2 == 0);
            intf.a        = 32'h3F80_0000;
            intf.b        = 32'h3F80_0000;
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, {31'd0, intf.out_valid}, 32'd1);
            check({tag, ".hold_result"}, intf.result, exp_res);
            check({tag, ".hold_in_ready"}, {31'd0, intf.in_ready}, 32'd0);
        end
        intf.in_valid  = 1'b0;
        intf.out_ready = 1'b1;
        @(posedge clk); #1;
        intf.out_ready = 1'b0;
        check({tag, ".retire_valid"}, {31'd0, intf.out_valid}, 32'd0);
        check({tag, ".retire_ready"}, {31'd0, intf.in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        intf.in_valid  = 1'b0;
        intf.out_ready = 1'b0;
        intf.a         = '0;
        intf.b         = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        check("reset.in_ready",  {31'd0, intf.in_ready},  32'd1);
        check("reset.out_valid", {31'd0, intf.out_valid}, 32'd0);
        check("reset.result",    intf.result,             32'd0);
        check("reset.overflow",  {31'd0, intf.overflow},  32'd0);

        // Normal path, 30-cycle latency
        do_op("div_6_2",     32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 30, 4'b0000, 0);
        do_op("div_m6_2",    32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 1'b0, 30, 4'b0000, 0);
        do_op("div_1_3",     32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 30, 4'b0001, 0);
        do_op("div_2_3",     32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB, 1'b0, 30, 4'b0001, 0);
        do_op("div_1_1",     32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 30, 4'b0000, 0);
        // Specials, 2-cycle latency
        do_op("div_1_0",     32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 2, 4'b1000, 0);
        do_op("div_m1_p0",   32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b0, 2, 4'b1000, 0);
        do_op("div_0_0",     32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 2, 4'b0100, 0);
        do_op("div_nan_1",   32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 2, 4'b0100, 0);
        do_op("div_inf_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0, 2, 4'b0100, 0);
        do_op("div_minf_2",  32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 2, 4'b0000, 0);
        do_op("div_m1_inf",  32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000, 1'b0, 2, 4'b0000, 0);
        do_op("div_denorm",  32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0, 2, 4'b0000, 0);
        // Range limits
        do_op("div_ovf",     32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 1'b1, 30, 4'b0001, 0);
        do_op("div_unf",     32'h0080_0000, 32'h4B00_0000, 32'h0000_0000, 1'b0, 30, 4'b0011, 0);

        // Backpressure: 5 cycles stalled in DONE with in_valid pokes
        do_op("bp_6_2",      32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 30, 4'b0000, 5);
        @(posedge clk); #1;
        check("bp.idle_valid",  {31'd0, intf.out_valid}, 32'd0);
        check("bp.idle_result", intf.result, 32'h4040_0000);

        // Reset abort during DIV
        intf.a        = 32'h40C0_0000;
        intf.b        = 32'h4000_0000;
        intf.in_valid = 1'b1;
        @(posedge clk); #1;
        intf.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort.out_valid", {31'd0, intf.out_valid}, 32'd0);
        check("abort.in_ready",  {31'd0, intf.in_ready},  32'd1);
        check("abort.result",    intf.result,             32'd0);
        check("abort.overflow",  {31'd0, intf.overflow},  32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("after_abort", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 30, 4'b0000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
